// File: rtl/spu_pkg.sv
// Shared widths, saturation limit and the in-flight entry layout for the ALU writeback pipe.
package spu_pkg;

    localparam int unsigned DATA_W      = 128;
    localparam int unsigned REG_ADDR_W  = 7;
    localparam int unsigned STALL_CNT_W = 32;

    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = {STALL_CNT_W{1'b1}};

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [REG_ADDR_W-1:0] rt;
        logic [DATA_W-1:0]     data;
        logic                  zero;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_stage.sv
// One pipeline slot: the valid bit is reset and flushable, the payload is captured only
// when a valid entry moves in, so it carries no reset.
module alu_wb_stage
    import spu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      advance,
    input  logic      load,
    input  logic      flush,
    input  wb_entry_t d,
    output wb_entry_t q
);

    logic                  valid_q;
    logic                  wr_en_q;
    logic [REG_ADDR_W-1:0] rt_q;
    logic [DATA_W-1:0]     data_q;
    logic                  zero_q;

    // Occupancy is carried by load; the incoming valid field is redundant here.
    logic unused_valid;
    assign unused_valid = d.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (advance) begin
            valid_q <= load;
        end
    end

    always_ff @(posedge clk) begin
        if (advance && load) begin
            wr_en_q <= d.wr_en;
            rt_q    <= d.rt;
            data_q  <= d.data;
            zero_q  <= d.zero;
        end
    end

    always_comb begin
        q       = '0;
        q.valid = valid_q;
        q.wr_en = wr_en_q;
        q.rt    = rt_q;
        q.data  = data_q;
        q.zero  = zero_q;
    end

endmodule

// File: rtl/alu_writeback_pipe.sv
// LATENCY-deep hold pipe between the SIMD ALU and the register-file write port, with a
// youngest-first forwarding lookup (built only when ALU_WB_FORWARD_EN is defined).
module alu_writeback_pipe
    import spu_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_result,
    input  logic                   in_zero,
    input  logic [REG_ADDR_W-1:0]  in_rt,
    input  logic                   in_wr_en,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [REG_ADDR_W-1:0]  wb_rt,
    output logic [DATA_W-1:0]      wb_data,
    output logic                   wb_zero,
    output logic                   wb_wr_en,
    input  logic [REG_ADDR_W-1:0]  fwd_ra,
    output logic                   fwd_hit,
    output logic [DATA_W-1:0]      fwd_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
        $error("alu_writeback_pipe: LATENCY must be 1..7");
    end

    wb_entry_t stage_d  [LATENCY];
    wb_entry_t stage_q  [LATENCY];
    logic      stage_ld [LATENCY];
    wb_entry_t out_q;
    logic      advance;
    logic      accept;
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    assign out_q    = stage_q[LATENCY-1];
    assign advance  = !out_q.valid || wb_ready;
    assign in_ready = advance && !flush;
    assign accept   = in_valid && in_ready;

    // Stage 0 takes the ALU entry; every later stage takes its predecessor wholesale.
    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign stage_d[k]  = '{valid: accept, wr_en: in_wr_en, rt: in_rt,
                                   data: in_result, zero: in_zero};
            assign stage_ld[k] = accept;
        end else begin : g_body
            assign stage_d[k]  = stage_q[k-1];
            assign stage_ld[k] = stage_q[k-1].valid;
        end

        alu_wb_stage u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (advance),
            .load    (stage_ld[k]),
            .flush   (flush),
            .d       (stage_d[k]),
            .q       (stage_q[k])
        );
    end

    // Payload registers are unreset, so the port is masked by the output valid bit.
    assign wb_valid = out_q.valid;
    assign wb_rt    = out_q.valid ? out_q.rt   : '0;
    assign wb_data  = out_q.valid ? out_q.data : '0;
    assign wb_zero  = out_q.valid && out_q.zero;
    assign wb_wr_en = out_q.valid && out_q.wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (out_q.valid && !wb_ready && stall_cnt_q != STALL_CNT_MAX) begin
            stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = stall_cnt_q;

`ifdef ALU_WB_FORWARD_EN
    // Walk oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = int'(LATENCY) - 1; k >= 0; k--) begin
            if (stage_q[k].valid && stage_q[k].wr_en && stage_q[k].rt == fwd_ra) begin
                fwd_hit  = 1'b1;
                fwd_data = stage_q[k].data;
            end
        end
    end
`else
    logic unused_fwd_ra;
    assign unused_fwd_ra = ^fwd_ra;
    assign fwd_hit       = 1'b0;
    assign fwd_data      = '0;
`endif

endmodule

// File: tb/tb_alu_writeback_pipe.sv
// Bench for alu_writeback_pipe: hand-computed vector table, directed corner sequences and a
// randomized run against a queue-based reference model. Honours ALU_WB_FORWARD_EN.
module tb_alu_writeback_pipe;
    import spu_pkg::*;

    localparam int unsigned L = 2;
`ifdef ALU_WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic                   clk;
    logic                   rst_n;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_W-1:0]      in_result;
    logic                   in_zero;
    logic [REG_ADDR_W-1:0]  in_rt;
    logic                   in_wr_en;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [REG_ADDR_W-1:0]  wb_rt;
    logic [DATA_W-1:0]      wb_data;
    logic                   wb_zero;
    logic                   wb_wr_en;
    logic [REG_ADDR_W-1:0]  fwd_ra;
    logic                   fwd_hit;
    logic [DATA_W-1:0]      fwd_data;
    logic [STALL_CNT_W-1:0] stall_cnt;

    alu_writeback_pipe #(.LATENCY(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_result (in_result),
        .in_zero   (in_zero),
        .in_rt     (in_rt),
        .in_wr_en  (in_wr_en),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_rt     (wb_rt),
        .wb_data   (wb_data),
        .wb_zero   (wb_zero),
        .wb_wr_en  (wb_wr_en),
        .fwd_ra    (fwd_ra),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: a queue of LATENCY slots (index 0 youngest), bubbles included.
    typedef struct {
        bit         v;
        bit         we;
        bit [6:0]   rt;
        bit [127:0] d;
        bit         z;
    } ment_t;

    ment_t     pipe[$];
    bit [31:0] m_cnt;
    bit [6:0]  retired[$];
    bit        last_ready;

    task automatic model_reset();
        ment_t b;
        b = '{v: 1'b0, we: 1'b0, rt: 7'd0, d: 128'd0, z: 1'b0};
        pipe.delete();
        repeat (L) pipe.push_back(b);
        m_cnt = 32'd0;
    endtask

    task automatic zero_inputs();
        flush = 1'b0; in_valid = 1'b0; in_result = '0; in_zero = 1'b0;
        in_rt = '0; in_wr_en = 1'b0; wb_ready = 1'b0; fwd_ra = '0;
    endtask

    // Drive one cycle at the falling edge, check every output against the model,
    // then advance the model to what the next rising edge must produce.
    task automatic cycle(input bit iv, input bit [6:0] rt, input bit [127:0] d, input bit z,
                         input bit we, input bit wbr, input bit fl, input bit [6:0] ra);
        ment_t      o;
        ment_t      e;
        ment_t      b;
        bit         adv;
        bit         rdy;
        bit         hit;
        bit [127:0] fd;
        @(negedge clk);
        in_valid = iv; in_rt = rt; in_result = d; in_zero = z; in_wr_en = we;
        wb_ready = wbr; flush = fl; fwd_ra = ra;
        #1;
        o   = pipe[L-1];
        adv = !o.v || wbr;
        rdy = adv && !fl;
        hit = 1'b0;
        fd  = 128'd0;
        if (FWD) begin
            for (int i = 0; i < int'(L); i++) begin
                if (pipe[i].v && pipe[i].we && pipe[i].rt == ra) begin
                    hit = 1'b1;
                    fd  = pipe[i].d;
                    break;
                end
            end
        end
        chk("wb_valid",  128'(wb_valid),  128'(o.v));
        chk("wb_rt",     128'(wb_rt),     128'(o.v ? o.rt : 7'd0));
        chk("wb_data",   wb_data,         o.v ? o.d : 128'd0);
        chk("wb_zero",   128'(wb_zero),   128'(o.v && o.z));
        chk("wb_wr_en",  128'(wb_wr_en),  128'(o.v && o.we));
        chk("in_ready",  128'(in_ready),  128'(rdy));
        chk("fwd_hit",   128'(fwd_hit),   128'(hit));
        chk("fwd_data",  fwd_data,        fd);
        chk("stall_cnt", 128'(stall_cnt), 128'(m_cnt));
        last_ready = in_ready;
        if (wb_valid && wbr && !fl) retired.push_back(wb_rt);
        if (o.v && !wbr && m_cnt != 32'hFFFF_FFFF) m_cnt++;
        b = '{v: 1'b0, we: 1'b0, rt: 7'd0, d: 128'd0, z: 1'b0};
        e = '{v: 1'b1, we: we, rt: rt, d: d, z: z};
        if (fl) begin
            foreach (pipe[i]) pipe[i].v = 1'b0;
        end else if (adv) begin
            void'(pipe.pop_back());
            pipe.push_front((iv && rdy) ? e : b);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        zero_inputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        retired.delete();
    endtask

    typedef struct {
        bit         iv;   bit [6:0] rt;   bit [127:0] d;   bit z;   bit we;  bit wbr; bit [6:0] ra;
        bit         e_v;  bit [6:0] e_rt; bit [127:0] e_d; bit e_z; bit e_we; bit e_rdy;
        bit         e_hit; bit [127:0] e_fd;
    } vec_t;

    vec_t tbl[16];

    initial begin
        bit [127:0] rd;
        bit         iv;
        bit         fl;
        int         next_rt;
        int         held;

        // Test 1: reset held for 3 cycles, outputs quiet.
        rst_n = 1'b0;
        zero_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wb_valid",  128'(wb_valid),  128'd0);
        chk("rst_in_ready",  128'(in_ready),  128'd1);
        chk("rst_stall_cnt", 128'(stall_cnt), 128'd0);
        chk("rst_fwd_hit",   128'(fwd_hit),   128'd0);
        rst_n = 1'b1;

        // Tests 2 and 4: latency, single-cycle writeback, stall, youngest-wins forwarding.
        tbl[0]  = '{1'b1, 7'd5, 128'd200000, 1'b1, 1'b1, 1'b1, 7'd5,
                    1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b0, 128'd0};
        tbl[1]  = '{1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 7'd5,
                    1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b1, 128'd200000};
        tbl[2]  = '{1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 7'd5,
                    1'b1, 7'd5, 128'd200000, 1'b1, 1'b1, 1'b1, 1'b1, 128'd200000};
        tbl[3]  = '{1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 7'd5,
                    1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b0, 128'd0};
        tbl[4]  = '{1'b1, 7'd9, 128'h55, 1'b0, 1'b1, 1'b0, 7'd9,
                    1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b0, 128'd0};
        tbl[5]  = '{1'b1, 7'd9, 128'hAA, 1'b0, 1'b1, 1'b0, 7'd9,
                    1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b1, 128'h55};
        tbl[6]  = '{1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b0, 7'd9,
                    1'b1, 7'd9, 128'h55, 1'b0, 1'b1, 1'b0, 1'b1, 128'hAA};
        tbl[7]  = '{1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 7'd9,
                    1'b1, 7'd9, 128'h55, 1'b0, 1'b1, 1'b1, 1'b1, 128'hAA};
        tbl[8]  = '{1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 7'd9,
                    1'b1, 7'd9, 128'hAA, 1'b0, 1'b1, 1'b1, 1'b1, 128'hAA};
        tbl[9]  = '{1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 7'd9,
                    1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b0, 128'd0};
        tbl[10] = '{1'b1, 7'd9, 128'h55, 1'b0, 1'b0, 1'b0, 7'd9,
                    1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b0, 128'd0};
        tbl[11] = '{1'b1, 7'd9, 128'hAA, 1'b0, 1'b0, 1'b0, 7'd9,
                    1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b0, 128'd0};
        tbl[12] = '{1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b0, 7'd9,
                    1'b1, 7'd9, 128'h55, 1'b0, 1'b0, 1'b0, 1'b0, 128'd0};
        tbl[13] = '{1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 7'd9,
                    1'b1, 7'd9, 128'h55, 1'b0, 1'b0, 1'b1, 1'b0, 128'd0};
        tbl[14] = '{1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 7'd9,
                    1'b1, 7'd9, 128'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 128'd0};
        tbl[15] = '{1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 7'd9,
                    1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b0, 128'd0};

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i].iv, tbl[i].rt, tbl[i].d, tbl[i].z, tbl[i].we, tbl[i].wbr, 1'b0, tbl[i].ra);
            chk($sformatf("vec%0d_wb_valid", i), 128'(wb_valid), 128'(tbl[i].e_v));
            chk($sformatf("vec%0d_wb_rt", i),    128'(wb_rt),    128'(tbl[i].e_rt));
            chk($sformatf("vec%0d_wb_data", i),  wb_data,        tbl[i].e_d);
            chk($sformatf("vec%0d_wb_zero", i),  128'(wb_zero),  128'(tbl[i].e_z));
            chk($sformatf("vec%0d_wb_wr_en", i), 128'(wb_wr_en), 128'(tbl[i].e_we));
            chk($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_fwd_hit", i),  128'(fwd_hit),  128'(tbl[i].e_hit & FWD));
            chk($sformatf("vec%0d_fwd_data", i), fwd_data,       tbl[i].e_fd & {128{FWD}});
        end
        cycle(1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd0);
        chk("vec_stall_total", 128'(stall_cnt), 128'd2);

        // Test 3: back-to-back rt=1..4, output stalls from the 2nd entry for 5 cycles.
        do_reset();
        next_rt = 1;
        held    = 0;
        for (int c = 0; c < 40; c++) begin
            iv = (next_rt <= 4);
            cycle(iv, 7'(next_rt), 128'(next_rt * 1000), 1'b0, 1'b1,
                  (c < 3 || c >= 8), 1'b0, 7'(next_rt));
            if (iv && !last_ready) held++;
            if (iv && last_ready) next_rt++;
        end
        chk("seq_ready_dropped", 128'(held > 0), 128'd1);
        chk("seq_stall_cnt",     128'(stall_cnt), 128'd5);
        chk("seq_retire_count",  128'(retired.size()), 128'd4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("seq_retire_%0d", i), 128'(retired.size() > i ? retired[i] : 7'h7F),
                128'(i + 1));

        // Test 5: flush with two entries in flight, new input and wb_ready all concurrent.
        do_reset();
        cycle(1'b1, 7'd11, 128'h1111, 1'b0, 1'b1, 1'b0, 1'b0, 7'd11);
        cycle(1'b1, 7'd12, 128'h2222, 1'b0, 1'b1, 1'b0, 1'b0, 7'd11);
        retired.delete();
        cycle(1'b1, 7'd13, 128'h3333, 1'b0, 1'b1, 1'b1, 1'b1, 7'd11);
        chk("flush_in_ready", 128'(last_ready), 128'd0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b0, 7'd13);
            chk($sformatf("flush_wb_valid_%0d", i), 128'(wb_valid), 128'd0);
        end
        chk("flush_nothing_retired", 128'(retired.size()), 128'd0);

        // Test 6: stall counter saturation.
        do_reset();
        cycle(1'b1, 7'd3, 128'h33, 1'b0, 1'b1, 1'b0, 1'b0, 7'd0);
        cycle(1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        cycle(1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        @(posedge clk);
        #1;
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        repeat (3) cycle(1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd0);
        @(posedge clk);
        #1;
        chk("stall_saturated", 128'(stall_cnt), 128'h0FFFF_FFFF);

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            fl = ($urandom_range(0, 99) < 3);
            cycle($urandom_range(0, 9) < 7, 7'($urandom_range(0, 7)), rd, 1'($urandom),
                  1'($urandom), $urandom_range(0, 9) < 6, fl, 7'($urandom_range(0, 7)));
        end

        // Reset asserted mid-operation with a stalled, forwardable entry in flight.
        cycle(1'b1, 7'd6, 128'h66, 1'b0, 1'b1, 1'b0, 1'b0, 7'd6);
        cycle(1'b1, 7'd6, 128'h77, 1'b0, 1'b1, 1'b0, 1'b0, 7'd6);
        cycle(1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd6);
        cycle(1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd6);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_wb_valid",  128'(wb_valid),  128'd0);
        chk("midrst_stall_cnt", 128'(stall_cnt), 128'd0);
        chk("midrst_fwd_hit",   128'(fwd_hit),   128'd0);
        chk("midrst_in_ready",  128'(in_ready),  128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 7'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0, 7'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
